regfile_writeback: RTL and testbench

Writeback stage that drives the write port of the Beta register file (Rc address, write data, WERF). It accepts one retiring instruction per cycle from the execute stage and selects the write data from PC+4, the ALU result or a memory load response. For loads it waits on a valid-only memory response channel, with a timeout. It also exports bypass and pending-load information so the read/decode side can forward or stall.

---
 rtl/regfile_writeback_pkg.sv | 19 +
 rtl/regfile_writeback_timeout.sv | 44 ++++
 rtl/regfile_writeback.sv | 161 ++++++++++++++++
 tb/tb_regfile_writeback.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_pkg.sv
// rtl/regfile_writeback_pkg.sv - shared writeback encodings, zero-register index and state type
// Purpose: constants and types shared by the writeback stage and decode/control.
// Contents: WDSEL_* write-data select encodings, RF_ZERO_REG index, wb_state_e.
package regfile_writeback_pkg;

    localparam logic [1:0] WDSEL_PC  = 2'd0;
    localparam logic [1:0] WDSEL_ALU = 2'd1;
    localparam logic [1:0] WDSEL_MEM = 2'd2;
    localparam logic [1:0] WDSEL_RSV = 2'd3;

    // R31 always reads zero, so writes to it are dropped.
    localparam int RF_ZERO_REG = 31;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/regfile_writeback_timeout.sv
// rtl/regfile_writeback_timeout.sv - 8-bit load-wait timeout counter
// Purpose: counts cycles spent waiting for a load response.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   clear_i       restart the count at zero (new load issued)
//   enable_i      a wait cycle elapsed without a response
//   expired_o     this enabled cycle is the LIMIT-th consecutive wait cycle
module wb_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Flagged in the cycle whose increment would reach LIMIT, so the owner
    // can leave the wait state on that same edge.
    assign expired_o = enable_i && !clear_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - Beta register-file writeback stage with load wait and bypass
// Purpose: selects PC+4 / ALU / load data and drives the register-file write port;
//   waits for loads with a timeout; exports bypass and pending-load information.
// Optional feature macro: REGFILE_WB_BYPASS_EN (bypass outputs live; tied to 0 otherwise).
// Ports:
//   clk_i, rst_i                         clock, asynchronous active-high reset
//   wb_valid_i / wb_ready_o              retiring-instruction handshake
//   wb_rc_i, wb_werf_i, wb_wdsel_i       destination, write enable, data select
//   wb_pc_i, wb_alu_i                    PC+4 and ALU result
//   mem_rvalid_i, mem_rdata_i            load response (valid only)
//   rc_o, wd_o, werf_o                   registered register-file write port
//   byp_valid_o, byp_rc_o, byp_data_o    forwarding of this cycle's write
//   pend_o, pend_rc_o                    outstanding load and its destination
//   err_o                                sticky error (reserved wdsel or load timeout)
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int ZERO_REG    = RF_ZERO_REG,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_valid_i,
    output logic              wb_ready_o,
    input  logic [ADDR_W-1:0] wb_rc_i,
    input  logic              wb_werf_i,
    input  logic [1:0]        wb_wdsel_i,
    input  logic [DATA_W-1:0] wb_pc_i,
    input  logic [DATA_W-1:0] wb_alu_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [ADDR_W-1:0] rc_o,
    output logic [DATA_W-1:0] wd_o,
    output logic              werf_o,
    output logic              byp_valid_o,
    output logic [ADDR_W-1:0] byp_rc_o,
    output logic [DATA_W-1:0] byp_data_o,
    output logic              pend_o,
    output logic [ADDR_W-1:0] pend_rc_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] ZERO_RC = ADDR_W'(ZERO_REG);

    wb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] rc_q, rc_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              werf_q, werf_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] ld_rc_q, ld_rc_d;
    logic              ld_werf_q, ld_werf_d;

    logic accept;
    logic cnt_clear;
    logic cnt_enable;
    logic cnt_expired;

    assign wb_ready_o = (state_q == IDLE) && !rst_i;
    assign accept     = wb_valid_i && wb_ready_o;
    assign cnt_clear  = accept && (wb_wdsel_i == WDSEL_MEM);
    assign cnt_enable = (state_q == WAIT_MEM) && !mem_rvalid_i;

    wb_timeout_counter #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (cnt_clear),
        .enable_i  (cnt_enable),
        .expired_o (cnt_expired)
    );

    always_comb begin
        state_d   = state_q;
        rc_d      = rc_q;
        wd_d      = wd_q;
        werf_d    = 1'b0;          // write enable is a single-cycle pulse
        err_d     = err_q;
        ld_rc_d   = ld_rc_q;
        ld_werf_d = ld_werf_q;

        case (state_q)
            IDLE: begin
                // Stale load responses are ignored here.
                if (accept) begin
                    case (wb_wdsel_i)
                        WDSEL_PC, WDSEL_ALU: begin
                            rc_d   = wb_rc_i;
                            wd_d   = (wb_wdsel_i == WDSEL_PC) ? wb_pc_i : wb_alu_i;
                            werf_d = wb_werf_i && (wb_rc_i != ZERO_RC);
                        end
                        WDSEL_MEM: begin
                            ld_rc_d   = wb_rc_i;
                            ld_werf_d = wb_werf_i;
                            state_d   = WAIT_MEM;
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            WAIT_MEM: begin
                // A response in the expiry cycle wins over the timeout.
                if (mem_rvalid_i) begin
                    rc_d    = ld_rc_q;
                    wd_d    = mem_rdata_i;
                    werf_d  = ld_werf_q && (ld_rc_q != ZERO_RC);
                    state_d = IDLE;
                end else if (cnt_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rc_q      <= '0;
            wd_q      <= '0;
            werf_q    <= 1'b0;
            err_q     <= 1'b0;
            ld_rc_q   <= '0;
            ld_werf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rc_q      <= rc_d;
            wd_q      <= wd_d;
            werf_q    <= werf_d;
            err_q     <= err_d;
            ld_rc_q   <= ld_rc_d;
            ld_werf_q <= ld_werf_d;
        end
    end

    assign rc_o      = rc_q;
    assign wd_o      = wd_q;
    assign werf_o    = werf_q;
    assign err_o     = err_q;
    assign pend_o    = (state_q == WAIT_MEM);
    assign pend_rc_o = pend_o ? ld_rc_q : '0;

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the value the register file commits at the end of this cycle.
    assign byp_valid_o = werf_q;
    assign byp_rc_o    = rc_q;
    assign byp_data_o  = wd_q;
`else
    assign byp_valid_o = 1'b0;
    assign byp_rc_o    = '0;
    assign byp_data_o  = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed scoreboard bench for regfile_writeback
module tb_regfile_writeback;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wb_valid_i;
    logic        wb_ready_o;
    logic [4:0]  wb_rc_i;
    logic        wb_werf_i;
    logic [1:0]  wb_wdsel_i;
    logic [31:0] wb_pc_i;
    logic [31:0] wb_alu_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [4:0]  rc_o;
    logic [31:0] wd_o;
    logic        werf_o;
    logic        byp_valid_o;
    logic [4:0]  byp_rc_o;
    logic [31:0] byp_data_o;
    logic        pend_o;
    logic [4:0]  pend_rc_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_writes = 0;
    logic [36:0] exp_q[$];

    regfile_writeback #(
        .DATA_W      (32),
        .ADDR_W      (5),
        .ZERO_REG    (31),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wb_valid_i   (wb_valid_i),
        .wb_ready_o   (wb_ready_o),
        .wb_rc_i      (wb_rc_i),
        .wb_werf_i    (wb_werf_i),
        .wb_wdsel_i   (wb_wdsel_i),
        .wb_pc_i      (wb_pc_i),
        .wb_alu_i     (wb_alu_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .rc_o         (rc_o),
        .wd_o         (wd_o),
        .werf_o       (werf_o),
        .byp_valid_o  (byp_valid_o),
        .byp_rc_o     (byp_rc_o),
        .byp_data_o   (byp_data_o),
        .pend_o       (pend_o),
        .pend_rc_o    (pend_rc_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the oldest expected write.
    always @(negedge clk_i) begin
        if (!rst_i && werf_o === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write_rc", {27'd0, rc_o}, 32'hFFFF_FFFF);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("sb_rc", {27'd0, rc_o}, {27'd0, e[36:32]});
                check("sb_wd", wd_o, e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid_i   = 1'b0;
        wb_rc_i      = 5'd0;
        wb_werf_i    = 1'b0;
        wb_wdsel_i   = 2'd0;
        wb_pc_i      = 32'd0;
        wb_alu_i     = 32'd0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'd0;
    endtask

    task automatic issue(input logic [4:0] rc, input logic [1:0] sel, input logic [31:0] pc,
                         input logic [31:0] alu);
        wb_valid_i = 1'b1;
        wb_rc_i    = rc;
        wb_werf_i  = 1'b1;
        wb_wdsel_i = sel;
        wb_pc_i    = pc;
        wb_alu_i   = alu;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        #1;
    endtask

    initial begin
        int w;
        idle_inputs();
        rst_i = 1'b1;
        step();
        // Reset state
        check("rst_werf", {31'd0, werf_o}, 32'd0);
        check("rst_rc", {27'd0, rc_o}, 32'd0);
        check("rst_wd", wd_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_pend", {31'd0, pend_o}, 32'd0);
        check("rst_pend_rc", {27'd0, pend_rc_o}, 32'd0);
        check("rst_byp", {byp_valid_o, byp_rc_o, byp_data_o[25:0]}, 32'd0);
        check("rst_ready", {31'd0, wb_ready_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, wb_ready_o}, 32'd1);

        // 1: back-to-back ALU writes
        issue(5'd3, 2'd1, 32'd0, 32'h0000_1234);
        exp_q.push_back({5'd3, 32'h0000_1234});
        step();
        check("b2b_werf0", {31'd0, werf_o}, 32'd1);
        issue(5'd4, 2'd1, 32'd0, 32'hFFFF_FFFF);
        exp_q.push_back({5'd4, 32'hFFFF_FFFF});
        check("b2b_ready", {31'd0, wb_ready_o}, 32'd1);
        step();
        check("b2b_werf1", {31'd0, werf_o}, 32'd1);
        check("b2b_rc1", {27'd0, rc_o}, 32'd4);
        idle_inputs();
        step();
        check("b2b_werf_drop", {31'd0, werf_o}, 32'd0);

        // 2: delayed load to R7
        issue(5'd7, 2'd2, 32'd0, 32'd0);
        step();
        idle_inputs();
        check("ld_ready", {31'd0, wb_ready_o}, 32'd0);
        check("ld_pend", {31'd0, pend_o}, 32'd1);
        check("ld_pend_rc", {27'd0, pend_rc_o}, 32'd7);
        step();
        step();
        check("ld_pend_late", {31'd0, pend_o}, 32'd1);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE_F00D;
        exp_q.push_back({5'd7, 32'hCAFE_F00D});
        step();
        idle_inputs();
        check("ld_werf", {31'd0, werf_o}, 32'd1);
        check("ld_wd", wd_o, 32'hCAFE_F00D);
        check("ld_pend_clr", {31'd0, pend_o}, 32'd0);
        check("ld_ready_back", {31'd0, wb_ready_o}, 32'd1);
        step();

        // 3: R31 suppression
        w = n_writes;
        issue(5'd31, 2'd1, 32'd0, 32'h5555_AAAA);
        step();
        idle_inputs();
        check("r31_alu_werf", {31'd0, werf_o}, 32'd0);
        issue(5'd31, 2'd2, 32'd0, 32'd0);
        step();
        idle_inputs();
        check("r31_ld_pend", {31'd0, pend_o}, 32'd1);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1111_2222;
        step();
        idle_inputs();
        check("r31_ld_werf", {31'd0, werf_o}, 32'd0);
        check("r31_ld_pend_clr", {31'd0, pend_o}, 32'd0);
        step();
        check("r31_no_writes", n_writes, w);

        // 4a: timeout with no response
        issue(5'd5, 2'd2, 32'd0, 32'd0);
        step();
        idle_inputs();
        step();
        step();
        step();
        check("to_pend_before", {31'd0, pend_o}, 32'd1);
        check("to_err_before", {31'd0, err_o}, 32'd0);
        step();
        check("to_err", {31'd0, err_o}, 32'd1);
        check("to_pend_clr", {31'd0, pend_o}, 32'd0);
        check("to_ready", {31'd0, wb_ready_o}, 32'd1);
        check("to_werf", {31'd0, werf_o}, 32'd0);
        w = n_writes;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        check("to_stale_werf", {31'd0, werf_o}, 32'd0);
        step();
        check("to_err_sticky", {31'd0, err_o}, 32'd1);
        check("to_no_writes", n_writes, w);

        // 4b: response on exactly the 4th wait cycle
        do_reset();
        check("err_cleared", {31'd0, err_o}, 32'd0);
        issue(5'd6, 2'd2, 32'd0, 32'd0);
        step();
        idle_inputs();
        step();
        step();
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0BAD_F00D;
        exp_q.push_back({5'd6, 32'h0BAD_F00D});
        step();
        idle_inputs();
        check("edge_werf", {31'd0, werf_o}, 32'd1);
        check("edge_err", {31'd0, err_o}, 32'd0);
        step();

        // 5: reset in the middle of a load (async: checked before any edge)
        issue(5'd9, 2'd2, 32'd0, 32'd0);
        step();
        idle_inputs();
        step();
        rst_i = 1'b1;
        #2;
        check("mid_rst_pend", {31'd0, pend_o}, 32'd0);
        check("mid_rst_ready", {31'd0, wb_ready_o}, 32'd0);
        check("mid_rst_rc", {27'd0, rc_o}, 32'd0);
        check("mid_rst_wd", wd_o, 32'd0);
        step();
        rst_i = 1'b0;
        w = n_writes;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h7777_7777;
        step();
        idle_inputs();
        check("mid_rst_stale", {31'd0, werf_o}, 32'd0);
        step();
        check("mid_rst_no_writes", n_writes, w);

        // 6: bypass and reserved wdsel
        issue(5'd1, 2'd0, 32'h0000_0104, 32'hAAAA_0000);
        exp_q.push_back({5'd1, 32'h0000_0104});
        step();
        idle_inputs();
        check("pc_wd", wd_o, 32'h0000_0104);
`ifdef REGFILE_WB_BYPASS_EN
        check("byp_valid", {31'd0, byp_valid_o}, 32'd1);
        check("byp_rc", {27'd0, byp_rc_o}, 32'd1);
        check("byp_data", byp_data_o, 32'h0000_0104);
`else
        check("byp_valid", {31'd0, byp_valid_o}, 32'd0);
        check("byp_rc", {27'd0, byp_rc_o}, 32'd0);
        check("byp_data", byp_data_o, 32'd0);
`endif
        step();
        issue(5'd2, 2'd3, 32'h1, 32'h2);
        step();
        idle_inputs();
        check("rsv_werf", {31'd0, werf_o}, 32'd0);
        check("rsv_err", {31'd0, err_o}, 32'd1);
        check("rsv_ready", {31'd0, wb_ready_o}, 32'd1);
        step();
        step();

        check("sb_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
